// File: rtl/sps_match_host.sv
// Host-side initiator for the stone-paper-scissors game core.
// Takes move pairs over valid/ready, fires one start pulse per round, samples
// the core result a fixed number of cycles later and keeps the match tally.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | ready for a move pair, last round's moves still on the core
// S_ISSUE | start pulse to the core with the accepted moves
// S_WAIT  | counting down to the result sample; moves held
// S_DONE  | a player reached WIN_TARGET; everything frozen until clear/rst
module sps_match_host #(
   parameter int RESULT_WAIT = 2,
   parameter int WIN_TARGET  = 3,
   parameter int SCORE_W     = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               clear,
   input  logic               move_valid,
   output logic               move_ready,
   input  logic [1:0]         p1_move,
   input  logic [1:0]         p2_move,
   output logic [1:0]         game_p1,
   output logic [1:0]         game_p2,
   output logic               game_start,
   input  logic [1:0]         game_result,
   output logic [SCORE_W-1:0] p1_score,
   output logic [SCORE_W-1:0] p2_score,
   output logic [SCORE_W-1:0] tie_count,
   output logic [SCORE_W-1:0] invalid_count,
   output logic [SCORE_W-1:0] round_count,
   output logic [1:0]         last_result,
   output logic               match_done,
   output logic [1:0]         match_winner
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam int WAIT_W = (RESULT_WAIT > 1) ? $clog2(RESULT_WAIT + 1) : 1;
   localparam logic [WAIT_W-1:0]  WAIT_LOAD = WAIT_W'(RESULT_WAIT);
   localparam logic [WAIT_W-1:0]  WAIT_LAST = WAIT_W'(1);
   localparam logic [SCORE_W-1:0] CNT_MAX   = {SCORE_W{1'b1}};
   localparam logic [SCORE_W-1:0] WIN_LAST  = SCORE_W'(WIN_TARGET - 1);

   state_t               state_q, state_d;
   logic [WAIT_W-1:0]    wait_cnt_q, wait_cnt_d;
   logic                 move_ready_q, move_ready_d;
   logic [1:0]           game_p1_q, game_p1_d;
   logic [1:0]           game_p2_q, game_p2_d;
   logic                 game_start_q, game_start_d;
   logic [SCORE_W-1:0]   p1_score_q, p1_score_d;
   logic [SCORE_W-1:0]   p2_score_q, p2_score_d;
   logic [SCORE_W-1:0]   tie_count_q, tie_count_d;
   logic [SCORE_W-1:0]   invalid_count_q, invalid_count_d;
   logic [SCORE_W-1:0]   round_count_q, round_count_d;
   logic [1:0]           last_result_q, last_result_d;
   logic                 match_done_q, match_done_d;
   logic [1:0]           match_winner_q, match_winner_d;

   function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
      return (v == CNT_MAX) ? v : v + 1'b1;
   endfunction

   // Next-state and next-output logic; every output is registered.
   always_comb begin
      state_d         = state_q;
      wait_cnt_d      = wait_cnt_q;
      move_ready_d    = move_ready_q;
      game_p1_d       = game_p1_q;
      game_p2_d       = game_p2_q;
      game_start_d    = 1'b0;
      p1_score_d      = p1_score_q;
      p2_score_d      = p2_score_q;
      tie_count_d     = tie_count_q;
      invalid_count_d = invalid_count_q;
      round_count_d   = round_count_q;
      last_result_d   = last_result_q;
      match_done_d    = match_done_q;
      match_winner_d  = match_winner_q;

      unique case (state_q)
         S_IDLE: begin
            if (move_valid && move_ready_q) begin
               game_p1_d    = p1_move;
               game_p2_d    = p2_move;
               game_start_d = 1'b1;
               move_ready_d = 1'b0;
               state_d      = S_ISSUE;
            end
         end
         S_ISSUE: begin
            wait_cnt_d = WAIT_LOAD;
            state_d    = S_WAIT;
         end
         S_WAIT: begin
            if (wait_cnt_q == WAIT_LAST) begin
               last_result_d = game_result;
               round_count_d = sat_inc(round_count_q);
               unique case (game_result)
                  2'b00: tie_count_d = sat_inc(tie_count_q);
                  2'b01: begin
                     p1_score_d = p1_score_q + 1'b1;
                     if (p1_score_q == WIN_LAST) begin
                        match_done_d   = 1'b1;
                        match_winner_d = 2'b01;
                     end
                  end
                  2'b10: begin
                     p2_score_d = p2_score_q + 1'b1;
                     if (p2_score_q == WIN_LAST) begin
                        match_done_d   = 1'b1;
                        match_winner_d = 2'b10;
                     end
                  end
                  default: invalid_count_d = sat_inc(invalid_count_q);
               endcase
               if (match_done_d) begin
                  state_d      = S_DONE;
                  move_ready_d = 1'b0;
               end else begin
                  state_d      = S_IDLE;
                  move_ready_d = 1'b1;
               end
            end else begin
               wait_cnt_d = wait_cnt_q - 1'b1;
            end
         end
         S_DONE: begin
            move_ready_d = 1'b0;
         end
         default: begin
            state_d      = S_IDLE;
            move_ready_d = 1'b1;
         end
      endcase
   end

   // State and output registers; clear aborts exactly like reset.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         state_q         <= S_IDLE;
         wait_cnt_q      <= '0;
         move_ready_q    <= 1'b1;
         game_p1_q       <= 2'b00;
         game_p2_q       <= 2'b00;
         game_start_q    <= 1'b0;
         p1_score_q      <= '0;
         p2_score_q      <= '0;
         tie_count_q     <= '0;
         invalid_count_q <= '0;
         round_count_q   <= '0;
         last_result_q   <= 2'b00;
         match_done_q    <= 1'b0;
         match_winner_q  <= 2'b00;
      end else begin
         state_q         <= state_d;
         wait_cnt_q      <= wait_cnt_d;
         move_ready_q    <= move_ready_d;
         game_p1_q       <= game_p1_d;
         game_p2_q       <= game_p2_d;
         game_start_q    <= game_start_d;
         p1_score_q      <= p1_score_d;
         p2_score_q      <= p2_score_d;
         tie_count_q     <= tie_count_d;
         invalid_count_q <= invalid_count_d;
         round_count_q   <= round_count_d;
         last_result_q   <= last_result_d;
         match_done_q    <= match_done_d;
         match_winner_q  <= match_winner_d;
      end
   end

   assign move_ready    = move_ready_q;
   assign game_p1       = game_p1_q;
   assign game_p2       = game_p2_q;
   assign game_start    = game_start_q;
   assign p1_score      = p1_score_q;
   assign p2_score      = p2_score_q;
   assign tie_count     = tie_count_q;
   assign invalid_count = invalid_count_q;
   assign round_count   = round_count_q;
   assign last_result   = last_result_q;
   assign match_done    = match_done_q;
   assign match_winner  = match_winner_q;

endmodule

// File: tb/tb_sps_match_host.sv
// Bench for sps_match_host: stand-in game core, round-level reference model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_sps_match_host;

   localparam int RW  = 2;
   localparam int WT  = 3;
   localparam int SW  = 8;
   localparam int MAX = (1 << SW) - 1;

   logic          clk = 1'b0;
   logic          rst, clear, move_valid, move_ready, game_start;
   logic [1:0]    p1_move, p2_move, game_p1, game_p2, game_result;
   logic [1:0]    last_result, match_winner;
   logic          match_done;
   logic [SW-1:0] p1_score, p2_score, tie_count, invalid_count, round_count;

   int n_checks = 0;
   int n_err    = 0;

   sps_match_host #(.RESULT_WAIT(RW), .WIN_TARGET(WT), .SCORE_W(SW)) dut (
      .clk(clk), .rst(rst), .clear(clear),
      .move_valid(move_valid), .move_ready(move_ready),
      .p1_move(p1_move), .p2_move(p2_move),
      .game_p1(game_p1), .game_p2(game_p2), .game_start(game_start),
      .game_result(game_result),
      .p1_score(p1_score), .p2_score(p2_score), .tie_count(tie_count),
      .invalid_count(invalid_count), .round_count(round_count),
      .last_result(last_result), .match_done(match_done),
      .match_winner(match_winner)
   );

   always #5 clk = ~clk;

   function automatic logic [1:0] rps(input logic [1:0] a, input logic [1:0] b);
      if (a == 2'b11 || b == 2'b11) return 2'b11;
      if (a == b) return 2'b00;
      if ((a == 2'b00 && b == 2'b10) || (a == 2'b01 && b == 2'b00) ||
          (a == 2'b10 && b == 2'b01)) return 2'b01;
      return 2'b10;
   endfunction

   // Stand-in core: the true result is only valid RW cycles after start,
   // otherwise it shows 11 so a mistimed sample gets counted as invalid.
   int core_age = 100;
   always @(posedge clk) begin
      if (game_start) core_age <= 1;
      else if (core_age < 100) core_age <= core_age + 1;
   end
   assign game_result = (core_age == RW) ? rps(game_p1, game_p2) : 2'b11;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s t=%0t actual=%0d expected=%0d", name, $time, act, exp);
      end
   endtask

   // Reference model: a round is "in flight" for RW+2 cycles after accept.
   bit busy = 0, m_done = 0;
   int phase = 0;
   int m_p1 = 0, m_p2 = 0, m_s1 = 0, m_s2 = 0, m_tie = 0, m_inv = 0;
   int m_rnd = 0, m_last = 0, m_win = 0;

   task automatic model_reset();
      busy = 0; m_done = 0; phase = 0; m_p1 = 0; m_p2 = 0; m_s1 = 0; m_s2 = 0;
      m_tie = 0; m_inv = 0; m_rnd = 0; m_last = 0; m_win = 0;
   endtask

   task automatic model_step();
      int r;
      if (rst || clear) begin
         model_reset();
      end else if (busy) begin
         phase++;
         if (phase == RW + 2) begin
            busy = 0;
            r = int'(rps(2'(m_p1), 2'(m_p2)));
            m_last = r;
            if (m_rnd < MAX) m_rnd++;
            case (r)
               0: if (m_tie < MAX) m_tie++;
               1: begin m_s1++; if (m_s1 == WT) begin m_done = 1; m_win = 1; end end
               2: begin m_s2++; if (m_s2 == WT) begin m_done = 1; m_win = 2; end end
               default: if (m_inv < MAX) m_inv++;
            endcase
         end
      end else if (!m_done && move_valid) begin
         busy = 1; phase = 1; m_p1 = int'(p1_move); m_p2 = int'(p2_move);
      end
   endtask

   // Every-cycle comparison of all outputs against the model.
   always @(posedge clk) begin
      model_step();
      #1;
      chk("move_ready",    int'(move_ready),    int'(!busy && !m_done));
      chk("game_start",    int'(game_start),    int'(busy && phase == 1));
      chk("game_p1",       int'(game_p1),       m_p1);
      chk("game_p2",       int'(game_p2),       m_p2);
      chk("p1_score",      int'(p1_score),      m_s1);
      chk("p2_score",      int'(p2_score),      m_s2);
      chk("tie_count",     int'(tie_count),     m_tie);
      chk("invalid_count", int'(invalid_count), m_inv);
      chk("round_count",   int'(round_count),   m_rnd);
      chk("last_result",   int'(last_result),   m_last);
      chk("match_done",    int'(match_done),    int'(m_done));
      chk("match_winner",  int'(match_winner),  m_win);
   end

   // Present a move pair for one cycle, return at the first cycle the result is visible.
   task automatic do_round(input logic [1:0] a, input logic [1:0] b);
      @(negedge clk); move_valid = 1; p1_move = a; p2_move = b;
      @(negedge clk); move_valid = 0;
      repeat (RW + 1) @(negedge clk);
   endtask

   task automatic do_clear();
      @(negedge clk); clear = 1;
      @(negedge clk); clear = 0;
   endtask

   initial begin
      int starts;
      rst = 1; clear = 0; move_valid = 0; p1_move = 0; p2_move = 0;
      repeat (3) @(negedge clk);
      rst = 0;
      chk("rst_ready", int'(move_ready), 1);
      chk("rst_start", int'(game_start), 0);
      chk("rst_round", int'(round_count), 0);

      // stone vs scissors -> P1 win, with cycle-exact timing
      @(negedge clk); move_valid = 1; p1_move = 2'b00; p2_move = 2'b10;
      @(negedge clk); move_valid = 0;
      chk("t1_start_c1", int'(game_start), 1);
      chk("t1_p1_c1", int'(game_p1), 0);
      chk("t1_p2_c1", int'(game_p2), 2);
      chk("t1_ready_c1", int'(move_ready), 0);
      @(negedge clk);
      chk("t1_start_c2", int'(game_start), 0);
      chk("t1_p2_c2", int'(game_p2), 2);
      @(negedge clk);
      chk("t1_round_c3", int'(round_count), 0);
      @(negedge clk);
      chk("t1_p1score_c4", int'(p1_score), 1);
      chk("t1_round_c4", int'(round_count), 1);
      chk("t1_last_c4", int'(last_result), 1);
      chk("t1_ready_c4", int'(move_ready), 1);

      // tie then invalid move
      do_clear();
      do_round(2'b10, 2'b10);
      do_round(2'b11, 2'b00);
      chk("t2_tie", int'(tie_count), 1);
      chk("t2_inv", int'(invalid_count), 1);
      chk("t2_p1", int'(p1_score), 0);
      chk("t2_p2", int'(p2_score), 0);
      chk("t2_round", int'(round_count), 2);
      chk("t2_last", int'(last_result), 3);

      // P2 takes the match; later offers ignored
      do_clear();
      do_round(2'b00, 2'b01);
      do_round(2'b00, 2'b01);
      chk("t3_done_early", int'(match_done), 0);
      do_round(2'b00, 2'b01);
      chk("t3_done", int'(match_done), 1);
      chk("t3_winner", int'(match_winner), 2);
      chk("t3_p2", int'(p2_score), 3);
      chk("t3_ready", int'(move_ready), 0);
      do_round(2'b01, 2'b00);
      do_round(2'b10, 2'b01);
      chk("t3_round_after", int'(round_count), 3);
      chk("t3_p1_after", int'(p1_score), 0);

      // clear during WAIT of round 2 while a move is offered
      do_clear();
      do_round(2'b01, 2'b00);
      @(negedge clk); move_valid = 1; p1_move = 2'b01; p2_move = 2'b00;
      @(negedge clk); move_valid = 0;
      @(negedge clk); clear = 1; move_valid = 1;
      @(negedge clk); clear = 0; move_valid = 0;
      chk("t4_round", int'(round_count), 0);
      chk("t4_p1", int'(p1_score), 0);
      chk("t4_ready", int'(move_ready), 1);
      chk("t4_start", int'(game_start), 0);
      repeat (6) @(negedge clk);
      chk("t4_round_later", int'(round_count), 0);

      // valid held high for four rounds
      @(negedge clk); move_valid = 1; p1_move = 2'b10; p2_move = 2'b10;
      starts = 0;
      repeat (4 * (RW + 2)) begin
         @(negedge clk);
         if (game_start) starts++;
      end
      chk("t5_starts", starts, 4);
      chk("t5_round", int'(round_count), 4);
      chk("t5_tie", int'(tie_count), 4);
      move_valid = 0;
      @(negedge clk);

      // reset during ISSUE
      @(negedge clk); move_valid = 1; p1_move = 2'b00; p2_move = 2'b10;
      @(negedge clk); move_valid = 0; rst = 1;
      chk("t6_start_issue", int'(game_start), 1);
      @(negedge clk); rst = 0;
      chk("t6_start", int'(game_start), 0);
      chk("t6_round", int'(round_count), 0);
      chk("t6_tie", int'(tie_count), 0);
      chk("t6_ready", int'(move_ready), 1);
      chk("t6_p2", int'(game_p2), 0);
      repeat (5) @(negedge clk);
      chk("t6_round_later", int'(round_count), 0);
      chk("t6_p1_later", int'(p1_score), 0);

      // counter saturation over 256 tied rounds
      @(negedge clk); move_valid = 1; p1_move = 2'b01; p2_move = 2'b01;
      repeat (256 * (RW + 2)) @(negedge clk);
      move_valid = 0;
      chk("t7_tie_sat", int'(tie_count), MAX);
      chk("t7_round_sat", int'(round_count), MAX);
      chk("t7_done", int'(match_done), 0);
      repeat (3) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/sps_match_host.md
Name: sps_match_host

Overview:
- Initiator side of the stone-paper-scissors game core interface.
- Accepts move pairs from a host-side valid/ready port and drives the core's move and start inputs as one-cycle start pulses.
- After a fixed wait it samples the core's 2-bit result and keeps a best-of-N tally.
- Sits beside the game core in the top-level; the top packs game_p1/game_p2/game_start onto ui_in and feeds result bits back from uo_out.

Parameters:
RESULT_WAIT, 2, cycles from start pulse to result sample (>=1)
WIN_TARGET, 3, round wins needed to take the match (1..2^SCORE_W-1)
SCORE_W, 8, width of every counter

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous active-high reset
clear  input  1  synchronous match clear (counters and FSM), single-cycle pulse
move_valid  input  1  host offers a move pair
move_ready  output  1  block can accept a move pair
p1_move  input  2  player 1 move: 00 stone, 01 paper, 10 scissors, 11 invalid
p2_move  input  2  player 2 move, same encoding
game_p1  output  2  move driven to core
game_p2  output  2  move driven to core
game_start  output  1  one-cycle start pulse to core
game_result  input  2  core result: 00 tie, 01 P1 win, 10 P2 win, 11 invalid
p1_score  output  SCORE_W  P1 round wins
p2_score  output  SCORE_W  P2 round wins
tie_count  output  SCORE_W  tied rounds
invalid_count  output  SCORE_W  rounds with result 11
round_count  output  SCORE_W  rounds completed
last_result  output  2  most recent sampled result
match_done  output  1  a player reached WIN_TARGET
match_winner  output  2  01 P1, 10 P2, 00 while match_done=0

Behaviour:
- Interface: clock is clk; reset is rst, synchronous and active-high.
- Reset: FSM to IDLE. All counters 0, last_result=00, match_winner=00, match_done=0. game_p1/game_p2=00, game_start=0, move_ready=1 from the first cycle after reset.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE: move_ready=1. Accept on move_valid&&move_ready at the edge: latch p1_move/p2_move and go to ISSUE.
- ISSUE: one cycle. game_start=1 and game_p1/game_p2 = latched moves. Next state is WAIT with the wait counter loaded to RESULT_WAIT.
- WAIT: game_start=0 and moves held on game_p1/game_p2. Lasts exactly RESULT_WAIT cycles.
- On the last WAIT cycle, game_result is sampled. At that edge:
  - last_result updates.
  - round_count increments.
  - Result 00 increments tie_count; 01 increments p1_score; 10 increments p2_score; 11 increments invalid_count only.
- After the sample edge: if the incremented p1_score or p2_score equals WIN_TARGET, go to DONE with match_done=1 and match_winner=01 or 10. Otherwise go to IDLE.
- Latency: accept edge to counter update is RESULT_WAIT+2 cycles. The next accept is possible on the cycle the counters are visible.
- game_p1/game_p2 keep the last round's moves while in IDLE/DONE. They change only when the next round enters ISSUE.
- move_ready=0 in ISSUE, WAIT and DONE. move_valid is ignored in those states, with no buffering.
- DONE: all outputs hold until clear or rst.
- clear: from any state, takes effect at the same edge as rst. game_start=0 on the following cycle and any round in flight is aborted with no counter update.
- clear and move_valid in the same cycle: clear wins and the move is not accepted.
- Saturation:
  - tie_count, invalid_count and round_count saturate at 2^SCORE_W-1; there is no wrap.
  - p1_score/p2_score cannot exceed WIN_TARGET.
- Invalid moves are forwarded unchanged; the block never pre-filters them. Invalid counting depends only on game_result.
- rst mid-round: behaves as clear; game_start=0 on the cycle after reset.

Test Plan:
- Reset, then move_valid with p1=00,p2=10 and the core model returning 01 -> game_start high exactly 1 cycle after accept; game_p1=00,game_p2=10 held 3 cycles; p1_score=1, round_count=1, last_result=01 at accept+4; move_ready high again at accept+4.
- Rounds scissors/scissors (result 00) then p1=11 (result 11) -> tie_count=1, invalid_count=1, p1_score=0, p2_score=0, round_count=2.
- Three P2-win rounds (p1=00,p2=01) -> match_done=1 and match_winner=10 at the third update; move_valid pulses afterward are ignored and counters are unchanged.
- clear asserted during WAIT of round 2, with move_valid also high that cycle -> no counter update, all counters 0, FSM in IDLE, move_ready=1 on the next cycle, and the move is not accepted.
- move_valid held high continuously for 4 rounds -> exactly one game_start per RESULT_WAIT+2 cycles and round_count=4.
- rst during ISSUE -> game_start=0 on the next cycle, all outputs at reset values, and the result presented afterward is not counted.
